// File: rtl/rsp_framer_if.sv
// ============================================================================
// rsp_framer_if : response stream in / framed byte stream out for rsp_framer
// Rev 1.0
// ============================================================================
`default_nettype none

interface rsp_framer_if;
   logic [31:0] param_data;
   logic        param_write;
   logic        cmd_done;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        overflow;

   modport master (
      output param_data, param_write, cmd_done, out_ready,
      input  out_data, out_valid, busy, overflow
   );

   modport slave (
      input  param_data, param_write, cmd_done, out_ready,
      output out_data, out_valid, busy, overflow
   );
endinterface

`default_nettype wire

// File: rtl/rsp_framer.sv
// ============================================================================
// rsp_framer : buffers parameter words and a response code, then emits one
//              framed response [n][rsp][params LE][xor] as a byte stream
// Rev 1.0
// ============================================================================
`default_nettype none

module rsp_framer #(
   parameter int MAX_PARAMS = 4,
   parameter int RSP_BITS   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   rsp_framer_if.slave  bus
);

   localparam logic [2:0] ST_COLLECT    = 3'd0;
   localparam logic [2:0] ST_SEND_LEN   = 3'd1;
   localparam logic [2:0] ST_SEND_RSP   = 3'd2;
   localparam logic [2:0] ST_SEND_PARAM = 3'd3;
   localparam logic [2:0] ST_SEND_SUM   = 3'd4;

   localparam logic [3:0] C_MAX_N = 4'(MAX_PARAMS);

   logic [2:0]  r_state, w_state_next;
   logic [3:0]  r_n, w_n_next;
   logic [31:0] r_buf [MAX_PARAMS];
   logic [7:0]  r_rsp, w_rsp_next;
   logic [7:0]  r_sum, w_sum_next;
   logic [7:0]  r_out_data, w_out_data_next;
   logic        r_out_valid, w_out_valid_next;
   logic        r_busy, w_busy_next;
   logic        r_overflow, w_overflow_next;
   logic [3:0]  r_word_idx, w_word_idx_next;
   logic [1:0]  r_byte_idx, w_byte_idx_next;

   logic        w_fire;
   logic        w_full;
   logic        w_store;
   logic        w_last_byte;
   logic [3:0]  w_n_after;
   logic [3:0]  w_rd_idx;
   logic [1:0]  w_rd_byte;
   logic [31:0] w_rd_word;
   logic [7:0]  w_rd_data;

   assign w_fire      = r_out_valid & bus.out_ready;
   assign w_full      = (r_n == C_MAX_N);
   assign w_store     = (r_state == ST_COLLECT) & bus.param_write & ~w_full;
   assign w_n_after   = w_store ? r_n + 4'd1 : r_n;
   assign w_last_byte = (r_byte_idx == 2'd3) && (r_word_idx == r_n - 4'd1);

   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.overflow  = r_overflow;

   // Parameter byte that follows the one currently on the bus
   always_comb begin
      w_rd_idx  = 4'd0;
      w_rd_byte = 2'd0;
      if (r_state == ST_SEND_PARAM) begin
         if (r_byte_idx == 2'd3) begin
            w_rd_idx = r_word_idx + 4'd1;
         end else begin
            w_rd_idx  = r_word_idx;
            w_rd_byte = r_byte_idx + 2'd1;
         end
      end
      w_rd_word = 32'd0;
      for (int i = 0; i < MAX_PARAMS; i++) begin
         if (w_rd_idx == 4'(i)) begin
            w_rd_word = r_buf[i];
         end
      end
      case (w_rd_byte)
         2'd0:    w_rd_data = w_rd_word[7:0];
         2'd1:    w_rd_data = w_rd_word[15:8];
         2'd2:    w_rd_data = w_rd_word[23:16];
         default: w_rd_data = w_rd_word[31:24];
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_store) begin
         for (int i = 0; i < MAX_PARAMS; i++) begin
            if (r_n == 4'(i)) begin
               r_buf[i] <= bus.param_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_COLLECT:    if (bus.cmd_done) w_state_next = ST_SEND_LEN;
         ST_SEND_LEN:   if (w_fire) w_state_next = ST_SEND_RSP;
         ST_SEND_RSP:   if (w_fire) w_state_next = (r_n == 4'd0) ? ST_SEND_SUM : ST_SEND_PARAM;
         ST_SEND_PARAM: if (w_fire && w_last_byte) w_state_next = ST_SEND_SUM;
         ST_SEND_SUM:   if (w_fire) w_state_next = ST_COLLECT;
         default:       w_state_next = ST_COLLECT;
      endcase
   end

   // Next values for the registered outputs and datapath; r_sum holds the XOR
   // of bytes already accepted, so the checksum is r_sum ^ the byte in flight.
   always_comb begin
      w_n_next         = r_n;
      w_rsp_next       = r_rsp;
      w_sum_next       = r_sum;
      w_out_data_next  = r_out_data;
      w_out_valid_next = r_out_valid;
      w_busy_next      = r_busy;
      w_overflow_next  = r_overflow;
      w_word_idx_next  = r_word_idx;
      w_byte_idx_next  = r_byte_idx;
      case (r_state)
         ST_COLLECT: begin
            if (w_store) begin
               w_n_next    = r_n + 4'd1;
               w_busy_next = 1'b1;
            end
            if (bus.param_write && w_full) begin
               w_overflow_next = 1'b1;
            end
            if (bus.cmd_done) begin
               w_rsp_next       = 8'(bus.param_data[RSP_BITS-1:0]);
               w_busy_next      = 1'b1;
               w_out_valid_next = 1'b1;
               w_out_data_next  = {4'b0, w_n_after};
               w_sum_next       = 8'd0;
            end
         end
         ST_SEND_LEN: begin
            if (w_fire) begin
               w_sum_next      = r_sum ^ r_out_data;
               w_out_data_next = r_rsp;
            end
         end
         ST_SEND_RSP: begin
            if (w_fire) begin
               w_sum_next      = r_sum ^ r_out_data;
               w_word_idx_next = 4'd0;
               w_byte_idx_next = 2'd0;
               w_out_data_next = (r_n == 4'd0) ? (r_sum ^ r_out_data) : w_rd_data;
            end
         end
         ST_SEND_PARAM: begin
            if (w_fire) begin
               w_sum_next = r_sum ^ r_out_data;
               if (w_last_byte) begin
                  w_out_data_next = r_sum ^ r_out_data;
               end else begin
                  w_out_data_next = w_rd_data;
                  w_word_idx_next = w_rd_idx;
                  w_byte_idx_next = w_rd_byte;
               end
            end
         end
         ST_SEND_SUM: begin
            if (w_fire) begin
               w_out_valid_next = 1'b0;
               w_out_data_next  = 8'd0;
               w_busy_next      = 1'b0;
               w_n_next         = 4'd0;
            end
         end
         default: ;
      endcase
      if (r_state != ST_COLLECT && (bus.param_write || bus.cmd_done)) begin
         w_overflow_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_n         <= 4'd0;
         r_rsp       <= 8'd0;
         r_sum       <= 8'd0;
         r_out_data  <= 8'd0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_overflow  <= 1'b0;
         r_word_idx  <= 4'd0;
         r_byte_idx  <= 2'd0;
      end else begin
         r_n         <= w_n_next;
         r_rsp       <= w_rsp_next;
         r_sum       <= w_sum_next;
         r_out_data  <= w_out_data_next;
         r_out_valid <= w_out_valid_next;
         r_busy      <= w_busy_next;
         r_overflow  <= w_overflow_next;
         r_word_idx  <= w_word_idx_next;
         r_byte_idx  <= w_byte_idx_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rsp_framer.sv
// ============================================================================
// tb_rsp_framer : directed scoreboard bench for rsp_framer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rsp_framer;

   localparam int MAXP = 4;

   logic clk;
   logic rst_n;
   rsp_framer_if bus ();

   rsp_framer #(.MAX_PARAMS(MAXP), .RSP_BITS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  exp_q [$];
   logic [31:0] mw [$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data  = 8'd0;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Reference frame: [n][rsp][words little-endian][xor of all preceding]
   task automatic push_frame(input logic [7:0] rsp);
      logic [7:0] s;
      logic [7:0] b;
      logic [31:0] w;
      s = 8'(mw.size());
      exp_q.push_back(s);
      exp_q.push_back(rsp);
      s = s ^ rsp;
      foreach (mw[k]) begin
         w = mw[k];
         for (int j = 0; j < 4; j++) begin
            b = w[8*j +: 8];
            exp_q.push_back(b);
            s = s ^ b;
         end
      end
      exp_q.push_back(s);
      mw.delete();
   endtask

   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.out_data), 32'(prev_data));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $error("FAIL unexpected_byte: observed=%0h expected=none", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               check("frame_byte", 32'(bus.out_data), 32'(e));
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [31:0] d);
      bus.param_data  = d;
      bus.param_write = 1'b1;
      if (mw.size() < MAXP) mw.push_back(d);
      step(1);
      bus.param_write = 1'b0;
   endtask

   task automatic pulse_cmd(input logic [31:0] d, input bit model);
      bus.param_data = d;
      bus.cmd_done   = 1'b1;
      if (model) push_frame(d[7:0]);
      step(1);
      bus.cmd_done = 1'b0;
   endtask

   // Runs until the frame drains; returns the number of clocks taken
   task automatic wait_idle(input bit bp, output int cycles);
      bit pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      cycles = 0;
      while (!(bus.busy === 1'b0 && exp_q.size() == 0)) begin
         if (cycles >= 200) begin
            total++;
            bad++;
            $error("FAIL idle_timeout: observed=%0d cycles expected=<200", cycles);
            break;
         end
         if (bp) bus.out_ready = pat[cycles % 4];
         step(1);
         cycles++;
      end
      bus.out_ready = 1'b1;
   endtask

   initial begin
      int cyc;
      rst_n           = 1'b0;
      bus.param_data  = 32'd0;
      bus.param_write = 1'b0;
      bus.cmd_done    = 1'b0;
      bus.out_ready   = 1'b1;
      step(3);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      rst_n = 1'b1;
      step(2);

      // n=0 frame, upper bits of param_data must not leak into rsp
      pulse_cmd(32'hABCD_0005, 1'b1);
      check("n0_first_valid", 32'(bus.out_valid), 32'd1);
      check("n0_busy", 32'(bus.busy), 32'd1);
      wait_idle(1'b0, cyc);
      check("n0_latency", 32'(cyc), 32'd3);
      check("n0_out_valid_after", 32'(bus.out_valid), 32'd0);

      // Two parameters
      write_word(32'h1122_3344);
      check("param_busy", 32'(bus.busy), 32'd1);
      write_word(32'hAABB_CCDD);
      pulse_cmd(32'h0000_0007, 1'b1);
      wait_idle(1'b0, cyc);
      check("two_latency", 32'(cyc), 32'd11);
      check("two_overflow", 32'(bus.overflow), 32'd0);

      // Same frame under backpressure
      write_word(32'h1122_3344);
      write_word(32'hAABB_CCDD);
      pulse_cmd(32'h0000_0007, 1'b1);
      wait_idle(1'b1, cyc);
      check("bp_overflow", 32'(bus.overflow), 32'd0);

      // Word and cmd_done in the same cycle: word counts in the length
      bus.param_write = 1'b1;
      mw.push_back(32'h0BAD_F00D);
      pulse_cmd(32'h0BAD_F00D, 1'b1);
      bus.param_write = 1'b0;
      wait_idle(1'b0, cyc);
      check("same_cycle_latency", 32'(cyc), 32'd7);

      // cmd_done during SEND_PARAM is ignored but flagged
      write_word(32'h0102_0304);
      pulse_cmd(32'h0000_0042, 1'b1);
      step(2);
      pulse_cmd(32'h0000_0055, 1'b0);
      check("viol_overflow", 32'(bus.overflow), 32'd1);
      wait_idle(1'b0, cyc);
      check("viol_busy_done", 32'(bus.busy), 32'd0);

      // Asynchronous reset in the middle of SEND_PARAM
      write_word(32'hDEAD_BEEF);
      write_word(32'h0000_1234);
      pulse_cmd(32'h0000_0007, 1'b1);
      step(3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_overflow", 32'(bus.overflow), 32'd0);
      exp_q.delete();
      mw.delete();
      step(2);
      rst_n = 1'b1;
      step(1);
      pulse_cmd(32'h0000_0003, 1'b1);
      wait_idle(1'b0, cyc);
      check("post_rst_latency", 32'(cyc), 32'd3);

      // Buffer overflow: six words into a four-word buffer
      for (int i = 1; i <= 6; i++) write_word(32'(i));
      check("ovf_flag", 32'(bus.overflow), 32'd1);
      pulse_cmd(32'h0000_0009, 1'b1);
      wait_idle(1'b0, cyc);
      check("ovf_latency", 32'(cyc), 32'd19);
      write_word(32'hCAFE_F00D);
      pulse_cmd(32'h0000_0021, 1'b1);
      wait_idle(1'b0, cyc);
      check("ovf_sticky", 32'(bus.overflow), 32'd1);

      step(2);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
